// File: rtl/gate_sweep_checker_if.sv
// rtl/gate_sweep_checker_if.sv - stimulus/response bundle between the sweep checker and its environment
interface gate_sweep_checker_if;
    logic       start;
    logic       gate_out;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass_ok;
    logic [7:0] err_count;
    logic [1:0] vec_idx;
    logic [1:0] first_fail_idx;
    logic       first_fail_val;

    modport master (
        input  start,
        input  gate_out,
        output a,
        output b,
        output busy,
        output done,
        output pass_ok,
        output err_count,
        output vec_idx,
        output first_fail_idx,
        output first_fail_val
    );

    modport slave (
        output start,
        output gate_out,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass_ok,
        input  err_count,
        input  vec_idx,
        input  first_fail_idx,
        input  first_fail_val
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - clocked 4-vector sweep of a 2-input gate with truth-table check
// Optional first-failure capture is built when GATE_SWEEP_FAILLOG_EN is defined.
module gate_sweep_checker #(
    parameter logic [3:0] FUNC   = 4'b0001,
    parameter int         SETTLE = 2,
    parameter int         REPEAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_sweep_checker_if.master  sw
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [7:0] REPEAT_LAST = 8'(REPEAT - 1);

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] rep_q, rep_d;
    logic [1:0] vec_q, vec_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [7:0] err_q, err_d;
    logic       pass_q, pass_d;

    logic mismatch;
    logic last_sample;
    logic busy_o;
    logic done_o;

    assign mismatch    = (state_q == ST_SAMPLE) && (sw.gate_out != FUNC[vec_q]);
    assign last_sample = (vec_q == 2'd3) && (rep_q == REPEAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (sw.start) state_d = ST_DRIVE;
            ST_DRIVE:  if (settle_q == 4'd0) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = last_sample ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
        done_o = (state_q == ST_DONE);
    end

    always_comb begin
        settle_d = settle_q;
        rep_d    = rep_q;
        vec_d    = vec_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        pass_d   = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (sw.start) begin
                    settle_d = SETTLE_LOAD;
                    rep_d    = 8'd0;
                    vec_d    = 2'd0;
                    a_d      = 1'b0;
                    b_d      = 1'b0;
                    err_d    = 8'd0;
                    pass_d   = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (settle_q != 4'd0) settle_d = settle_q - 4'd1;
            end
            ST_SAMPLE: begin
                if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
                if (last_sample) begin
                    // Includes this final sample's result so pass_ok is valid during DONE.
                    pass_d = (err_d == 8'd0);
                    a_d    = 1'b0;
                    b_d    = 1'b0;
                end else begin
                    if (vec_q == 2'd3) rep_d = rep_q + 8'd1;
                    vec_d    = vec_q + 2'd1;
                    a_d      = vec_d[0];
                    b_d      = vec_d[1];
                    settle_d = SETTLE_LOAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= 4'd0;
            rep_q    <= 8'd0;
            vec_q    <= 2'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            err_q    <= 8'd0;
            pass_q   <= 1'b0;
        end else begin
            settle_q <= settle_d;
            rep_q    <= rep_d;
            vec_q    <= vec_d;
            a_q      <= a_d;
            b_q      <= b_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
        end
    end

`ifdef GATE_SWEEP_FAILLOG_EN
    logic [1:0] ff_idx_q, ff_idx_d;
    logic       ff_val_q, ff_val_d;

    // Only the first mismatch of a run is logged; err_q==0 marks "nothing seen yet".
    always_comb begin
        ff_idx_d = ff_idx_q;
        ff_val_d = ff_val_q;
        if ((state_q == ST_IDLE) && sw.start) begin
            ff_idx_d = 2'd0;
            ff_val_d = 1'b0;
        end else if (mismatch && (err_q == 8'd0)) begin
            ff_idx_d = vec_q;
            ff_val_d = sw.gate_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_idx_q <= 2'd0;
            ff_val_q <= 1'b0;
        end else begin
            ff_idx_q <= ff_idx_d;
            ff_val_q <= ff_val_d;
        end
    end

    assign sw.first_fail_idx = ff_idx_q;
    assign sw.first_fail_val = ff_val_q;
`else
    assign sw.first_fail_idx = 2'd0;
    assign sw.first_fail_val = 1'b0;
`endif

    assign sw.a         = a_q;
    assign sw.b         = b_q;
    assign sw.busy      = busy_o;
    assign sw.done      = done_o;
    assign sw.pass_ok   = pass_q;
    assign sw.err_count = err_q;
    assign sw.vec_idx   = vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - directed bench for gate_sweep_checker (NOR, NAND, saturation, reset abort)
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mode0 = 0;   // 0: NOR model, 1: tied 0, 2: tied 1

    always #5 clk = ~clk;

    gate_sweep_checker_if if0 ();
    gate_sweep_checker_if if1 ();
    gate_sweep_checker_if if2 ();

    assign if0.gate_out = (mode0 == 0) ? ~(if0.a | if0.b) : (mode0 == 2);
    assign if1.gate_out = 1'b1;
    assign if2.gate_out = ~(if2.a & if2.b);

    gate_sweep_checker #(.FUNC(4'b0001), .SETTLE(2), .REPEAT(1))
        u_nor  (.clk(clk), .rst_n(rst_n), .sw(if0.master));
    gate_sweep_checker #(.FUNC(4'b0001), .SETTLE(2), .REPEAT(100))
        u_rep  (.clk(clk), .rst_n(rst_n), .sw(if1.master));
    gate_sweep_checker #(.FUNC(4'b0111), .SETTLE(2), .REPEAT(1))
        u_nand (.clk(clk), .rst_n(rst_n), .sw(if2.master));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full sweep on u_nor with start at edge 0; optionally re-pulse start mid-sweep.
    task automatic sweep0(input bit repulse);
        logic [1:0] v;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            v = 2'(i / 3);
            check("a", 32'(if0.a), 32'(v[0]));
            check("b", 32'(if0.b), 32'(v[1]));
            check("vec_idx", 32'(if0.vec_idx), 32'(v));
            check("busy", 32'(if0.busy), 1);
            check("done_early", 32'(if0.done), 0);
            if (repulse) if0.start = (i == 4);
            @(negedge clk);
        end
        if0.start = 1'b0;
        check("done_pulse", 32'(if0.done), 1);
        check("busy_done", 32'(if0.busy), 0);
        check("a_done", 32'(if0.a), 0);
        check("b_done", 32'(if0.b), 0);
    endtask

    initial begin
        int n;
        int seen;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a", 32'(if0.a), 0);
        check("rst_b", 32'(if0.b), 0);
        check("rst_busy", 32'(if0.busy), 0);
        check("rst_done", 32'(if0.done), 0);
        check("rst_pass", 32'(if0.pass_ok), 0);
        check("rst_err", 32'(if0.err_count), 0);
        check("rst_vec", 32'(if0.vec_idx), 0);
        check("rst_ffi", 32'(if0.first_fail_idx), 0);
        check("rst_ffv", 32'(if0.first_fail_val), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct NOR model
        mode0 = 0;
        sweep0(1'b0);
        check("nor_err", 32'(if0.err_count), 0);
        check("nor_pass_done", 32'(if0.pass_ok), 1);
        @(negedge clk);
        check("nor_done_gone", 32'(if0.done), 0);
        check("nor_pass_hold", 32'(if0.pass_ok), 1);

        // gate_out tied 0, back-to-back with previous run's IDLE cycle
        mode0 = 1;
        sweep0(1'b0);
        check("t0_err", 32'(if0.err_count), 1);
        check("t0_pass", 32'(if0.pass_ok), 0);
        check("t0_ffi", 32'(if0.first_fail_idx), 0);
        check("t0_ffv", 32'(if0.first_fail_val), 0);
        @(negedge clk);

        // gate_out tied 1, with a start re-pulse while busy
        mode0 = 2;
        sweep0(1'b1);
        check("t1_err", 32'(if0.err_count), 3);
        check("t1_pass", 32'(if0.pass_ok), 0);
`ifdef GATE_SWEEP_FAILLOG_EN
        check("t1_ffi", 32'(if0.first_fail_idx), 1);
        check("t1_ffv", 32'(if0.first_fail_val), 1);
`else
        check("t1_ffi", 32'(if0.first_fail_idx), 0);
        check("t1_ffv", 32'(if0.first_fail_val), 0);
`endif
        @(negedge clk);
        check("t1_no_restart", 32'(if0.busy), 0);

        // REPEAT=100 with gate_out tied 1: saturation and done timing
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        n = 0;
        while (!if1.done && n < 1300) begin
            @(negedge clk);
            n++;
        end
        check("rep_done_edge", 32'(n), 1200);
        check("rep_err_sat", 32'(if1.err_count), 255);
        check("rep_pass", 32'(if1.pass_ok), 0);
        @(negedge clk);

        // NAND truth table with correct NAND model
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        n = 0;
        while (!if2.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("nand_done_edge", 32'(n), 12);
        check("nand_err", 32'(if2.err_count), 0);
        check("nand_pass", 32'(if2.pass_ok), 1);
        @(negedge clk);

        // Async reset during vector 2 of a failing run
        mode0 = 2;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (7) @(negedge clk);
        check("ab_pre_rst", 32'({if0.b, if0.a}), 32'b10);
        check("err_pre_rst", 32'(if0.err_count), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a", 32'(if0.a), 0);
        check("arst_b", 32'(if0.b), 0);
        check("arst_busy", 32'(if0.busy), 0);
        check("arst_err", 32'(if0.err_count), 0);
        check("arst_vec", 32'(if0.vec_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.done) seen++;
        end
        check("arst_no_done", 32'(seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
